// File: rtl/dsp_16add_uu.sv
// dsp_16add_uu: registered unsigned adder, one 32-bit add or two 16-bit adds.
// Define DSP_16ADD_INREG_EN to add an input register stage (2-cycle latency).
module dsp_16add_uu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mode,
  input  logic        carry_in,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  output logic [15:0] Out1,
  output logic [15:0] Out2,
  output logic        carry_out,
  output logic        carry_lo,
  output logic        out_valid
);

  logic [15:0] a_s, b_s, c_s, d_s;
  logic        cin_s, mode_s, vld_s;

`ifdef DSP_16ADD_INREG_EN
  logic [15:0] a_d, a_q, b_d, b_q;
  logic [15:0] c_d, c_q, d_d, d_q;
  logic        cin_d, cin_q;
  logic        mode_d, mode_q;
  logic        vld_d, vld_q;

  // Input stage loads every cycle so in_valid travels with its operands
  always_comb begin
    a_d    = A;
    b_d    = B;
    c_d    = C;
    d_d    = D;
    cin_d  = carry_in;
    mode_d = mode;
    vld_d  = in_valid;
  end

  // Input registers, cleared on reset to drop any in-flight operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      cin_q  <= 1'b0;
      mode_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      cin_q  <= cin_d;
      mode_q <= mode_d;
      vld_q  <= vld_d;
    end
  end

  assign a_s    = a_q;
  assign b_s    = b_q;
  assign c_s    = c_q;
  assign d_s    = d_q;
  assign cin_s  = cin_q;
  assign mode_s = mode_q;
  assign vld_s  = vld_q;
`else
  assign a_s    = A;
  assign b_s    = B;
  assign c_s    = C;
  assign d_s    = D;
  assign cin_s  = carry_in;
  assign mode_s = mode;
  assign vld_s  = in_valid;
`endif

  logic [16:0] lo_sum, hi_sum;
  logic [15:0] out1_d, out1_q;
  logic [15:0] out2_d, out2_q;
  logic        co_d, co_q;
  logic        cl_d, cl_q;
  logic        ov_d, ov_q;

  // Low half first; its carry reaches the high half only in cascaded mode
  always_comb begin
    lo_sum = {1'b0, b_s} + {1'b0, d_s} + {16'd0, cin_s};
    hi_sum = {1'b0, a_s} + {1'b0, c_s}
           + {16'd0, lo_sum[16] & ~mode_s};
    out1_d = out1_q;
    out2_d = out2_q;
    co_d   = co_q;
    cl_d   = cl_q;
    ov_d   = vld_s;
    if (vld_s) begin
      out1_d = hi_sum[15:0];
      out2_d = lo_sum[15:0];
      co_d   = hi_sum[16];
      cl_d   = lo_sum[16];
    end
  end

  // Result registers hold when no valid sample arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q <= '0;
      out2_q <= '0;
      co_q   <= 1'b0;
      cl_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      out1_q <= out1_d;
      out2_q <= out2_d;
      co_q   <= co_d;
      cl_q   <= cl_d;
      ov_q   <= ov_d;
    end
  end

  assign Out1      = out1_q;
  assign Out2      = out2_q;
  assign carry_out = co_q;
  assign carry_lo  = cl_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_dsp_16add_uu.sv
// tb_dsp_16add_uu: scoreboard bench for dsp_16add_uu.
// Directed vectors, random traffic and async reset against a 32-bit model.
module tb_dsp_16add_uu;

`ifdef DSP_16ADD_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        carry_in = 1'b0;
  logic [15:0] A = '0, B = '0, C = '0, D = '0;
  logic [15:0] Out1, Out2;
  logic        carry_out, carry_lo, out_valid;

  typedef struct {
    logic [15:0] o1;
    logic [15:0] o2;
    logic        co;
    logic        cl;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  dsp_16add_uu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .mode(mode), .carry_in(carry_in),
    .A(A), .B(B), .C(C), .D(D),
    .Out1(Out1), .Out2(Out2),
    .carry_out(carry_out), .carry_lo(carry_lo),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", nm, got, exp);
  endtask

  // Reference: whole-word arithmetic for mode 0, two split sums for mode 1
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic cin, input logic m,
                                 input int at);
    exp_t e;
    logic [32:0] s32;
    logic [16:0] lo, hi;
    lo = 17'(x[15:0]) + 17'(y[15:0]) + 17'(cin);
    if (!m) begin
      s32  = 33'(x) + 33'(y) + 33'(cin);
      e.o1 = s32[31:16];
      e.o2 = s32[15:0];
      e.co = s32[32];
    end else begin
      hi   = 17'(x[31:16]) + 17'(y[31:16]);
      e.o1 = hi[15:0];
      e.o2 = lo[15:0];
      e.co = hi[16];
    end
    e.cl  = lo[16];
    e.cyc = at;
    return e;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic cin, input logic m);
    @(posedge clk);
    #1;
    A = x[31:16]; B = x[15:0];
    C = y[31:16]; D = y[15:0];
    carry_in = cin; mode = m; in_valid = 1'b1;
    last = model(x, y, cin, m, cyc + LAT);
    q.push_back(last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom);
      C = 16'($urandom); D = 16'($urandom);
      carry_in = 1'($urandom); mode = 1'($urandom);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out1"}, 64'(Out1), 64'd0);
    chk({nm, "_out2"}, 64'(Out2), 64'd0);
    chk({nm, "_co"}, 64'(carry_out), 64'd0);
    chk({nm, "_cl"}, 64'(carry_lo), 64'd0);
    chk({nm, "_ov"}, 64'(out_valid), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("out1", 64'(Out1), 64'(e.o1));
          chk("out2", 64'(Out2), 64'(e.o2));
          chk("carry_out", 64'(carry_out), 64'(e.co));
          chk("carry_lo", 64'(carry_lo), 64'(e.cl));
          chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_result", 64'd0, 64'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst_n = 1'b1;

    issue(32'h67510B12, 32'hCD840A1F, 1'b0, 1'b0);
    issue(32'h7F7DF7D8, 32'hFFFFFFFF, 1'b0, 1'b0);
    issue(32'h55555556, 32'hFFFFFFFF, 1'b0, 1'b0);
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
    idle(LAT + 2);

    for (int i = 0; i < 4; i++)
      issue($urandom, $urandom, 1'($urandom), 1'($urandom));
    idle(LAT + 2);
    @(negedge clk);
    chk("hold_ov", 64'(out_valid), 64'd0);
    chk("hold_out1", 64'(Out1), 64'(last.o1));
    chk("hold_out2", 64'(Out2), 64'(last.o2));
    chk("hold_co", 64'(carry_out), 64'(last.co));
    chk("hold_cl", 64'(carry_lo), 64'(last.cl));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) != 0)
        issue($urandom, $urandom, 1'($urandom), 1'($urandom));
      else
        idle(1);
    end
    idle(LAT + 2);

    issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("post_rst");
    end
    issue(32'hFFFF0001, 32'h0001FFFF, 1'b0, 1'b0);
    idle(LAT + 2);

    chk("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
